// File: rtl/wb_burst_master.sv
// Wishbone B4 registered-feedback burst initiator: one command runs as a single
// linear incrementing burst, write data pulled from a stream, read data pushed to a stream.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// BURST  | bus cycle open, beats issued until the count reaches zero
// FINISH | command complete, done reported in the following cycle
module wb_burst_master #(
    parameter int ADR_W = 30,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [ADR_W-1:0] cmd_adr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_we,
    input  logic [31:0]      wr_dat,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [31:0]      rd_dat,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [ADR_W-1:0] wishbone_adr,
    output logic [31:0]      wishbone_dat_w,
    input  logic [31:0]      wishbone_dat_r,
    output logic             wishbone_cyc,
    output logic             wishbone_stb,
    input  logic             wishbone_ack,
    output logic             wishbone_we,
    output logic             wishbone_sel,
    output logic [2:0]       wishbone_cti,
    output logic [1:0]       wishbone_bte,
    input  logic             wishbone_err
);

    typedef enum logic [1:0] {IDLE, BURST, FINISH} state_t;

    state_t           state_q, state_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             we_q, we_d;
    logic [31:0]      rd_dat_q, rd_dat_d;
    logic             rd_valid_q, rd_valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             in_burst;
    logic             last_beat;
    logic             beat_ack;
    logic             beat_err;

    // Bus outputs derive from registered state; stb alone follows the write stream
    // so an empty stream becomes a master wait state without closing the cycle.
    assign in_burst       = (state_q == BURST);
    assign last_beat      = (rem_q == LEN_W'(1));
    assign wishbone_cyc   = in_burst;
    assign wishbone_stb   = in_burst & (~we_q | wr_valid);
    assign wishbone_we    = in_burst & we_q;
    assign wishbone_sel   = in_burst;
    assign wishbone_bte   = 2'b00;
    assign wishbone_cti   = in_burst ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
    assign wishbone_adr   = adr_q;
    assign wishbone_dat_w = wr_dat;

    // err has priority over ack on the same beat
    assign beat_err = wishbone_stb & wishbone_err;
    assign beat_ack = wishbone_stb & wishbone_ack & ~wishbone_err;

    assign cmd_ready = (state_q == IDLE);
    assign busy      = in_burst;
    assign wr_ready  = beat_ack & we_q;
    assign rd_dat    = rd_dat_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign err       = err_q;

    // Next-state and datapath updates for the command sequencer
    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        rem_d      = rem_q;
        we_d       = we_q;
        rd_dat_d   = rd_dat_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len != '0) begin
                        adr_d   = cmd_adr;
                        rem_d   = cmd_len;
                        we_d    = cmd_we;
                        state_d = BURST;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            BURST: begin
                if (beat_err) begin
                    rem_d   = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (beat_ack) begin
                    adr_d = adr_q + ADR_W'(1);
                    rem_d = rem_q - LEN_W'(1);
                    if (!we_q) begin
                        rd_dat_d   = wishbone_dat_r;
                        rd_valid_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared immediately by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            adr_q      <= '0;
            rem_q      <= '0;
            we_q       <= 1'b0;
            rd_dat_q   <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            rem_q      <= rem_d;
            we_q       <= we_d;
            rd_dat_q   <= rd_dat_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: doc/wb_burst_master.md
Name:
wb_burst_master

Overview:
- Wishbone B4 registered-feedback burst initiator, 32-bit data, word addressed.
- Drives the same bus the team's burst-capable Wishbone slaves (SRAM/FIFO DUTs) respond on; it is the traffic source for the burst-mode benchmark.
- Accepts one command: start address, beat count and direction.
- Runs it as a single linear incrementing burst. Write data is sourced from a stream; read data is delivered to a stream.

Parameters:
- ADR_W, 30, width of the word address.
- LEN_W, 8, width of the beat count; the maximum burst is 2^LEN_W-1 beats.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; a command is accepted on cmd_valid & cmd_ready
- cmd_adr  in  ADR_W  burst start word address
- cmd_len  in  LEN_W  number of beats
- cmd_we  in  1  1 = write burst, 0 = read burst
- wr_dat  in  32  write-data stream word
- wr_valid  in  1  wr_dat holds a valid word
- wr_ready  out  1  write word consumed this cycle
- rd_dat  out  32  read-data stream word
- rd_valid  out  1  rd_dat valid; one-cycle pulse, no backpressure
- busy  out  1  a command is in progress
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse when a burst is aborted by wishbone_err
- wishbone_adr  out  ADR_W  bus address
- wishbone_dat_w  out  32  bus write data
- wishbone_dat_r  in  32  bus read data
- wishbone_cyc  out  1  bus cycle
- wishbone_stb  out  1  bus strobe
- wishbone_ack  in  1  slave acknowledge
- wishbone_we  out  1  bus write enable
- wishbone_sel  out  1  byte select; tied to 1 while cyc is high, else 0
- wishbone_cti  out  3  cycle type identifier
- wishbone_bte  out  2  burst type extension; constant 2'b00 (linear)
- wishbone_err  in  1  slave error

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-burst):
  - State returns to IDLE.
  - cyc, stb, we, sel = 0; adr = 0; cti = 3'b000.
  - rd_valid, done, err, busy = 0; rd_dat = 0.
  - The beat counter is cleared and no partial done is reported.
- States: IDLE, BURST, FINISH.
- IDLE:
  - cmd_ready = 1.
  - On accept with cmd_len != 0: latch adr, remaining = cmd_len and we; go to BURST; cyc = 1 from the next cycle.
  - On accept with cmd_len == 0: go to FINISH with no bus activity.
- BURST:
  - cyc = 1, busy = 1.
  - For reads, stb = 1.
  - For writes, stb = wr_valid (combinational). A low wr_valid inserts a master wait state: cyc stays high, adr and cti are held.
  - wishbone_dat_w = wr_dat; wr_ready = wishbone_ack & stb & we.
  - cti = 3'b111 when remaining == 1, else 3'b010 (incrementing burst). A one-beat command therefore issues a classic cycle that is tagged end-of-burst.
  - On ack (with stb high): adr <= adr + 1, with wrap modulo 2^ADR_W; remaining <= remaining - 1.
    - For reads, also rd_dat <= wishbone_dat_r, and rd_valid pulses in the next cycle.
  - When remaining == 1 and ack arrives: deassert cyc/stb in the next cycle and go to FINISH.
- FINISH:
  - done = 1 for exactly one cycle; busy = 0; return to IDLE.
  - A new command can be accepted one cycle later, so there are no back-to-back cycles without an idle gap.
- Error:
  - If wishbone_err is sampled while cyc & stb are high, the burst aborts: cyc/stb go low in the next cycle and err pulses for one cycle.
  - done is NOT asserted. The state returns to IDLE.
  - The errored beat produces no rd_valid and no wr_ready.
- Simultaneous ack and err: err wins.
- ack while stb is low: ignored.
- busy = 1 from the cycle after accept until done/err is asserted.
- Latency:
  - With a zero-wait-state slave, an N-beat burst holds cyc for exactly N cycles.
  - done occurs N+1 cycles after the first cyc cycle.

Test Plan:
- Write burst, adr=0x10, len=4, wr stream 0xA0..0xA3 always valid, zero-wait slave:
  - cyc high for 4 cycles; adr 0x10..0x13; cti 010,010,010,111; bte 00.
  - wr_ready pulses 4 times; slave SRAM holds 0xA0..0xA3; done pulses once.
- Read burst, adr=0x10, len=4, from the preloaded SRAM:
  - rd_valid pulses 4 times with 0xA0..0xA3 in order, each one cycle after its ack.
  - done pulses once; the first read issues with we=0.
- Write burst len=3 with wr_valid low for 2 cycles before beat 2:
  - stb low for those 2 cycles while cyc stays high; adr and cti held.
  - The transfer completes with correct data; cyc is high for 5 cycles.
- len=1 read at 0x3F, and len=0:
  - len=1: a single cycle with cti=111 and adr=0x3F.
  - len=0: no cyc; done pulses 2 cycles after accept.
- Slave asserts err on beat 2 of a 4-beat read:
  - cyc drops the next cycle; err pulses once; exactly 1 rd_valid; no done.
  - cmd_ready is high the following cycle.
- reset asserted mid-burst at beat 2 of a 4-beat write:
  - cyc, stb and busy go low immediately, with no wait for a clock edge; no done.
  - After reset release, a new len=2 command runs normally from its own start address.
